rvee_dec_queue: RTL

RVEE_DEC_QUEUE -- requirements
Module: rvee_dec_queue

---
 rtl/rvee_dec_queue.sv | 118 +++++++++++
 1 files changed

// File: rtl/rvee_dec_queue.sv
// rvee_dec_queue: decode-to-execute queue with pending-write register scoreboard.
//
// A DEPTH-entry circular buffer that decouples decode (producer) from exec
// (consumer). Each entry carries an opaque decoded-instruction payload plus
// the destination register and its write-enable. busy_regs flags every GPR
// that has a pending write in some queued entry.
//
// Parameters:
//   XLEN  - datapath width; only used to size the default payload
//   DEPTH - entry count, power of two >= 2
//   DW    - payload width
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   in_valid/in_ready   - producer handshake
//   in_data, in_rd,
//   in_rd_we            - offered entry: payload, destination reg, write flag
//   out_valid/out_ready - consumer handshake
//   out_data            - head entry payload
//   flush               - discard all queued entries at the next edge
//   count               - number of valid entries
//   busy_regs           - per-GPR pending-write flags (bit 0 always 0)
module rvee_dec_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int DW    = 4*XLEN+32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic [4:0]               in_rd,
  input  logic                     in_rd_we,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              busy_regs
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [DEPTH-1:0] vld;

  // Payload storage is deliberately unreset; vld gates every use of it.
  logic [DW-1:0]    mem_data [DEPTH];
  logic [4:0]       mem_rd   [DEPTH];
  logic [DEPTH-1:0] mem_we;

  logic push;
  logic pop;

  // Both handshake outputs depend only on registered state (and rst), so
  // there is no combinational path between the producer and consumer sides.
  assign in_ready  = (count != FULL_CNT) && !rst;
  assign out_valid = (count != '0);
  assign out_data  = mem_data[rptr];

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else if (flush) begin
      // Collapse onto the write pointer; any same-cycle push/pop is ignored.
      rptr  <= wptr;
      count <= '0;
      vld   <= '0;
    end else begin
      // push and pop never target the same slot: pop needs count != 0 and
      // push needs count != DEPTH, so rptr == wptr cannot occur with both.
      if (push) begin
        wptr      <= wptr + PTR_ONE;
        vld[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr      <= rptr + PTR_ONE;
        vld[rptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= in_data;
      mem_rd[wptr]   <= in_rd;
      mem_we[wptr]   <= in_rd_we;
    end
  end

  // Scoreboard built from registered entries only; stale slots are masked
  // by vld so popped or flushed entries never report a pending write.
  always_comb begin
    busy_regs = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld[AW'(i)] && mem_we[AW'(i)]) begin
        busy_regs[mem_rd[AW'(i)]] = 1'b1;
      end
    end
    busy_regs[0] = 1'b0;
  end

endmodule
